// File: rtl/dense_int_pkg.sv
// Shared types and helpers for the dense-layer int8 feeder.
package dense_int_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_t;

  // Returns the number of bits needed to hold the value n itself, so counters can reach n.
  function automatic int clogb2(input int n);
    int v;
    int b;
    v = n;
    b = 0;
    while (v > 0) begin
      b++;
      v = v >> 1;
    end
    return (b == 0) ? 1 : b;
  endfunction

endpackage

// File: rtl/dense_int_feeder_if.sv
// Vector-in / element-out bus of the dense-layer feeder.
interface dense_int_feeder_if import dense_int_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int C = 8
);
  logic                         valid_i;
  logic [C*DATA_WIDTH-1:0]      data_i;
  logic                         ready_o;
  logic                         valid_o;
  logic signed [DATA_WIDTH-1:0] data_o;
  logic                         last_o;
  logic                         busy_o;

  modport master (output valid_i, data_i,
                  input  ready_o, valid_o, data_o, last_o, busy_o);
  modport slave  (input  valid_i, data_i,
                  output ready_o, valid_o, data_o, last_o, busy_o);
endinterface

// File: rtl/vec_fifo.sv
// Vector FIFO: DEPTH words of W bits; head word is read combinationally from a registered read pointer.
module vec_fifo import dense_int_pkg::*; #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int AW = clogb2(DEPTH - 1),
  localparam int CW = clogb2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/dense_int_feeder.sv
// Serializes C-element int8 vectors onto a GAP-paced strobe stream for a dense layer.
// Optional macro DENSE_FEEDER_RELU_EN clamps negative elements to zero at the output register.
module dense_int_feeder import dense_int_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int C = 8,
  parameter int D = 64,
  parameter int DEPTH = 4,
  parameter int GAP = 1
) (
  input logic clk,
  input logic rstn,
  dense_int_feeder_if.slave bus
);
  // state | meaning
  // IDLE  | no vector in flight; pop as soon as the FIFO has one
  // EMIT  | register one element onto the output strobe
  // WAIT  | GAP idle cycles, then next element, next vector, or IDLE
  localparam int VW = C * DATA_WIDTH;
  localparam int EW = clogb2(C);
  localparam int FW = clogb2(D - 1);
  localparam int GW = clogb2(GAP - 1);
  localparam int CW = clogb2(DEPTH);

  if ((D % C) != 0 || GAP < 1) begin : g_cfg_check
    $error("dense_int_feeder: D must be a multiple of C and GAP must be at least 1");
  end

  state_t                state, state_nx;
  logic                  pop, push, ready, fifo_ne;
  logic [CW-1:0]         count;
  logic [VW-1:0]         fifo_dout, vreg;
  logic [EW-1:0]         e_cnt;
  logic [FW-1:0]         f_cnt;
  logic [GW-1:0]         g_cnt;
  logic [DATA_WIDTH-1:0] elem_cur, elem_out, data_q;
  logic                  valid_q, last_q;

  assign ready   = (count != CW'(DEPTH));
  assign push    = bus.valid_i & ready;
  assign fifo_ne = (count != '0);

  vec_fifo #(.W(VW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (bus.data_i),
    .dout  (fifo_dout),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: if (fifo_ne) begin
        pop      = 1'b1;
        state_nx = EMIT;
      end
      EMIT: state_nx = WAIT;
      WAIT: if (g_cnt == '0) begin
        if (e_cnt != EW'(C)) begin
          state_nx = EMIT;
        end else if (fifo_ne) begin
          pop      = 1'b1;
          state_nx = EMIT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    elem_cur = '0;
    for (int i = 0; i < C; i++) begin
      if (e_cnt == EW'(i)) elem_cur = vreg[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef DENSE_FEEDER_RELU_EN
  assign elem_out = elem_cur[DATA_WIDTH-1] ? '0 : elem_cur;
`else
  assign elem_out = elem_cur;
`endif

  // data_q / last_q hold between strobes; only valid_q is a pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vreg    <= '0;
      e_cnt   <= '0;
      f_cnt   <= '0;
      g_cnt   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (pop) begin
        vreg  <= fifo_dout;
        e_cnt <= '0;
      end
      if (state == EMIT) begin
        valid_q <= 1'b1;
        data_q  <= elem_out;
        last_q  <= (f_cnt == FW'(D - 1));
        e_cnt   <= e_cnt + 1'b1;
        f_cnt   <= (f_cnt == FW'(D - 1)) ? '0 : f_cnt + 1'b1;
        g_cnt   <= GW'(GAP - 1);
      end else if (state == WAIT && g_cnt != '0) begin
        g_cnt <= g_cnt - 1'b1;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.last_o  = last_q;
  assign bus.busy_o  = fifo_ne | (state != IDLE);
endmodule
